vc_fifo: RTL and testbench

Multi-virtual-channel input buffer for a router input port: NUM_VC independent circular queues of DEPTH words each, sharing one write port and exposing every queue head at once for the VC/switch allocators. It replaces the single-queue port FIFO.
- Per-VC free counts double as credit counts returned upstream.
- Overflow and underflow are defined and safe: illegal operations are dropped, never corrupt state.
- Optional sticky error flags report illegal operations.

---
 rtl/vc_fifo.sv | 138 +++++++++++++
 tb/tb_vc_fifo.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_fifo.sv
// vc_fifo: multi-virtual-channel router input buffer.
// NUM_VC independent circular queues of DEPTH words share one write port.
// Every queue head is visible at once on dout, first-word-fall-through.
// The per-VC free counts double as the credit counts returned upstream.
// Illegal pushes and pops are dropped and never disturb queue state.
// Optional build macro VC_FIFO_ERR_EN adds sticky overflow/underflow flags.
// Without the macro, overflow_err and underflow_err are tied to 0.

module vc_fifo #(
    parameter  int NUM_VC     = 4,
    parameter  int DEPTH      = 5,
    parameter  int DATA_WIDTH = 32,
    localparam int VC_BITS    = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    localparam int CNT_BITS   = $clog2(DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic [VC_BITS-1:0]           push_vc,
    input  logic [DATA_WIDTH-1:0]        din,
    input  logic [NUM_VC-1:0]            pop,
    output logic [NUM_VC*DATA_WIDTH-1:0] dout,
    output logic [NUM_VC*CNT_BITS-1:0]   n_free,
    output logic [NUM_VC-1:0]            empty,
    output logic [NUM_VC-1:0]            full,
    output logic [NUM_VC-1:0]            overflow_err,
    output logic [NUM_VC-1:0]            underflow_err
);

    localparam int PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] r_mem   [NUM_VC][DEPTH];
    logic [PTR_BITS-1:0]   r_rdPtr [NUM_VC];
    logic [PTR_BITS-1:0]   r_wrPtr [NUM_VC];
    logic [CNT_BITS-1:0]   r_free  [NUM_VC];

    logic [NUM_VC-1:0] w_empty;
    logic [NUM_VC-1:0] w_full;
    logic [NUM_VC-1:0] w_wen;
    logic [NUM_VC-1:0] w_ren;

    // Heads step by one and wrap from DEPTH-1 back to 0, so DEPTH need not be a power of two.
    function automatic logic [PTR_BITS-1:0] nextPtr(input logic [PTR_BITS-1:0] p);
        if (p == PTR_BITS'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_BITS'(1);
    endfunction

    // Decode the status and enables for each VC from the registered free count.
    // A push to a full VC is still accepted when the same VC pops that cycle.
    // An out-of-range push_vc matches no VC, so that push is simply dropped.
    always_comb begin
        w_empty = '0;
        w_full  = '0;
        w_wen   = '0;
        w_ren   = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            w_empty[v] = (r_free[v] == CNT_BITS'(DEPTH));
            w_full[v]  = (r_free[v] == '0);
            w_wen[v]   = push && (int'(push_vc) == v) && (!w_full[v] || pop[v]);
            w_ren[v]   = pop[v] && !w_empty[v];
        end
    end

    // Queue state update: storage write, head advance and free-count tracking per VC.
    // On a full VC with push and pop together, the write head equals the read head.
    // The new word therefore lands in the slot being vacated and the count stays at 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int v = 0; v < NUM_VC; v++) begin
                r_rdPtr[v] <= '0;
                r_wrPtr[v] <= '0;
                r_free[v]  <= CNT_BITS'(DEPTH);
                for (int d = 0; d < DEPTH; d++) begin
                    r_mem[v][d] <= '0;
                end
            end
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (w_wen[v]) begin
                    r_mem[v][r_wrPtr[v]] <= din;
                    r_wrPtr[v]           <= nextPtr(r_wrPtr[v]);
                end
                if (w_ren[v]) begin
                    r_rdPtr[v] <= nextPtr(r_rdPtr[v]);
                end
                case ({w_wen[v], w_ren[v]})
                    2'b10:   r_free[v] <= r_free[v] - CNT_BITS'(1);
                    2'b01:   r_free[v] <= r_free[v] + CNT_BITS'(1);
                    default: r_free[v] <= r_free[v];
                endcase
            end
        end
    end

    // Pack the head words and free counts onto the flat output buses.
    always_comb begin
        dout   = '0;
        n_free = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            dout[v*DATA_WIDTH +: DATA_WIDTH] = r_mem[v][r_rdPtr[v]];
            n_free[v*CNT_BITS +: CNT_BITS]   = r_free[v];
        end
    end

    assign empty = w_empty;
    assign full  = w_full;

`ifdef VC_FIFO_ERR_EN
    logic [NUM_VC-1:0] r_ovfErr;
    logic [NUM_VC-1:0] r_unfErr;

    // Sticky error flags: record any illegal push or pop until the next reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovfErr <= '0;
            r_unfErr <= '0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (push && (int'(push_vc) == v) && w_full[v] && !pop[v]) begin
                    r_ovfErr[v] <= 1'b1;
                end
                if (pop[v] && w_empty[v]) begin
                    r_unfErr[v] <= 1'b1;
                end
            end
        end
    end

    assign overflow_err  = r_ovfErr;
    assign underflow_err = r_unfErr;
`else
    assign overflow_err  = '0;
    assign underflow_err = '0;
`endif

endmodule

// File: tb/tb_vc_fifo.sv
// tb_vc_fifo: scoreboard bench for vc_fifo.
// The main instance uses the defaults NUM_VC=4, DEPTH=5, DATA_WIDTH=32.
// A second instance with NUM_VC=6, DEPTH=3 exercises out-of-range push_vc values.
// Stimulus queues the expected words and a negedge monitor pops and compares them.

module tb_vc_fifo;

    localparam int NV = 4;
    localparam int DP = 5;
    localparam int DW = 32;
    localparam int CB = 4;

    localparam int NV6 = 6;
    localparam int DW6 = 8;
    localparam int CB6 = 3;

    logic              clk;
    logic              reset_n;
    logic              push;
    logic [1:0]        push_vc;
    logic [DW-1:0]     din;
    logic [NV-1:0]     pop;
    logic [NV*DW-1:0]  dout;
    logic [NV*CB-1:0]  n_free;
    logic [NV-1:0]     empty;
    logic [NV-1:0]     full;
    logic [NV-1:0]     overflow_err;
    logic [NV-1:0]     underflow_err;

    logic               push6;
    logic [2:0]         pushVc6;
    logic [DW6-1:0]     din6;
    logic [NV6-1:0]     pop6;
    logic [NV6*DW6-1:0] dout6;
    logic [NV6*CB6-1:0] nFree6;
    logic [NV6-1:0]     empty6;
    logic [NV6-1:0]     full6;
    logic [NV6-1:0]     ovf6;
    logic [NV6-1:0]     unf6;

    logic [DW-1:0] expQ [NV][$];
    logic [NV-1:0] expPopMask;
    logic [NV-1:0] expOvf;
    logic [NV-1:0] expUnf;

    int checkCount;
    int passCount;

    vc_fifo #(.NUM_VC(NV), .DEPTH(DP), .DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .push          (push),
        .push_vc       (push_vc),
        .din           (din),
        .pop           (pop),
        .dout          (dout),
        .n_free        (n_free),
        .empty         (empty),
        .full          (full),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    vc_fifo #(.NUM_VC(NV6), .DEPTH(3), .DATA_WIDTH(DW6)) dut6 (
        .clk           (clk),
        .reset_n       (reset_n),
        .push          (push6),
        .push_vc       (pushVc6),
        .din           (din6),
        .pop           (pop6),
        .dout          (dout6),
        .n_free        (nFree6),
        .empty         (empty6),
        .full          (full6),
        .overflow_err  (ovf6),
        .underflow_err (unf6)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counts it, and reports a FAIL line on mismatch.
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: on each negedge, every VC the stimulus expects to pop must show the queued head word.
    always @(negedge clk) begin
        if (reset_n) begin
            for (int v = 0; v < NV; v++) begin
                if (expPopMask[v]) begin
                    if (expQ[v].size() == 0) begin
                        checkCount++;
                        $display("[TB] FAIL scoreboard_vc%0d: got pop with 0 queued words, expected at least 1", v);
                    end else begin
                        check($sformatf("dout_vc%0d", v), 64'(dout[v*DW +: DW]), 64'(expQ[v].pop_front()));
                    end
                end
            end
        end
    end

    // Drive one cycle of inputs just after an edge; accepted words are queued as expected output.
    task automatic applyStimulus(input logic doPush, input logic [1:0] vc, input logic [DW-1:0] data,
                                 input logic [NV-1:0] doPop, input logic acceptPush, input logic [NV-1:0] acceptPop);
        push       = doPush;
        push_vc    = vc;
        din        = data;
        pop        = doPop;
        expPopMask = acceptPop;
        if (acceptPush) begin
            expQ[vc].push_back(data);
        end
        @(posedge clk);
        #1;
        push       = 1'b0;
        pop        = '0;
        expPopMask = '0;
    endtask

    // Compare the status outputs against hand-computed values and the expected error flags.
    task automatic checkOutput(input string tag, input logic [NV*CB-1:0] expFree,
                               input logic [NV-1:0] expEmpty, input logic [NV-1:0] expFull);
        check({tag, "_n_free"},    64'(n_free),        64'(expFree));
        check({tag, "_empty"},     64'(empty),         64'(expEmpty));
        check({tag, "_full"},      64'(full),          64'(expFull));
        check({tag, "_overflow"},  64'(overflow_err),  64'(expOvf));
        check({tag, "_underflow"}, 64'(underflow_err), 64'(expUnf));
    endtask

    // Directed sequence.
    initial begin
        checkCount = 0;
        passCount  = 0;
        reset_n    = 1'b0;
        push       = 1'b0;
        push_vc    = '0;
        din        = '0;
        pop        = '0;
        expPopMask = '0;
        expOvf     = '0;
        expUnf     = '0;
        push6      = 1'b0;
        pushVc6    = '0;
        din6       = '0;
        pop6       = '0;

        // Reset state
        #12;
        checkOutput("reset", 16'h5555, 4'hF, 4'h0);
        check("reset_dout", 64'(dout), 64'h0);
        check("reset_dut6_nfree", 64'(nFree6), 64'({6{3'd3}}));
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Out-of-range push_vc on the 6-VC instance is dropped; VC5 still works
        push6 = 1'b1; pushVc6 = 3'd6; din6 = 8'hC6;
        @(posedge clk); #1;
        pushVc6 = 3'd7; din6 = 8'hC7;
        @(posedge clk); #1;
        push6 = 1'b0;
        check("vc6_drop_nfree", 64'(nFree6), 64'({6{3'd3}}));
        check("vc6_drop_empty", 64'(empty6), 64'h3F);
        push6 = 1'b1; pushVc6 = 3'd5; din6 = 8'hAB;
        @(posedge clk); #1;
        push6 = 1'b0;
        check("vc6_vc5_nfree", 64'(nFree6), 64'({3'd2, {5{3'd3}}}));
        check("vc6_vc5_dout", 64'(dout6[5*DW6 +: DW6]), 64'hAB);

        // Fill VC2 then drain it in order
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 2'd2, 32'hA0 + 32'(i), 4'b0000, 1'b1, 4'b0000);
        checkOutput("fill_vc2", 16'h5055, 4'b1011, 4'b0100);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 2'd0, 32'h0, 4'b0100, 1'b0, 4'b0100);
        checkOutput("drain_vc2", 16'h5555, 4'hF, 4'h0);

        // Wrap-around on VC0
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'd0, 32'h1 + 32'(i), 4'b0000, 1'b1, 4'b0000);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'd0, 32'h0, 4'b0001, 1'b0, 4'b0001);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 2'd0, 32'h10 + 32'(i), 4'b0000, 1'b1, 4'b0000);
        checkOutput("wrap_full", 16'h5550, 4'b1110, 4'b0001);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 2'd0, 32'h0, 4'b0001, 1'b0, 4'b0001);
        checkOutput("wrap_drain", 16'h5555, 4'hF, 4'h0);

        // Full VC1: push with same-cycle pop, then push without pop is dropped
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 2'd1, 32'h20 + 32'(i), 4'b0000, 1'b1, 4'b0000);
        applyStimulus(1'b1, 2'd1, 32'h55, 4'b0010, 1'b1, 4'b0010);
        checkOutput("full_pushpop", 16'h5505, 4'b1101, 4'b0010);
        applyStimulus(1'b1, 2'd1, 32'h66, 4'b0000, 1'b0, 4'b0000);
`ifdef VC_FIFO_ERR_EN
        expOvf = 4'b0010;
`endif
        checkOutput("full_drop", 16'h5505, 4'b1101, 4'b0010);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 2'd0, 32'h0, 4'b0010, 1'b0, 4'b0010);
        checkOutput("full_drain", 16'h5555, 4'hF, 4'h0);

        // Empty VC0: push with same-cycle pop, the pop is ignored
        applyStimulus(1'b1, 2'd0, 32'h77, 4'b0001, 1'b1, 4'b0000);
`ifdef VC_FIFO_ERR_EN
        expUnf = 4'b0001;
`endif
        checkOutput("empty_pushpop", 16'h5554, 4'b1110, 4'h0);
        check("empty_pushpop_dout0", 64'(dout[0 +: DW]), 64'h77);

        // Push VC3 while popping VC0 and VC1 together
        applyStimulus(1'b1, 2'd1, 32'h31, 4'b0000, 1'b1, 4'b0000);
        applyStimulus(1'b1, 2'd3, 32'h99, 4'b0011, 1'b1, 4'b0011);
        checkOutput("multi_vc", 16'h4555, 4'b0111, 4'h0);
        check("multi_vc_dout3", 64'(dout[3*DW +: DW]), 64'h99);

        // Asynchronous reset mid-stream, away from any clock edge
        applyStimulus(1'b1, 2'd2, 32'h42, 4'b0000, 1'b1, 4'b0000);
        #2;
        reset_n = 1'b0;
        #1;
        for (int v = 0; v < NV; v++) expQ[v].delete();
        expOvf = '0;
        expUnf = '0;
        checkOutput("async_reset", 16'h5555, 4'hF, 4'h0);
        check("async_reset_dout", 64'(dout), 64'h0);
        check("async_reset_dut6_nfree", 64'(nFree6), 64'({6{3'd3}}));
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        applyStimulus(1'b1, 2'd1, 32'hBEEF, 4'b0000, 1'b1, 4'b0000);
        checkOutput("post_reset", 16'h5545, 4'b1101, 4'h0);
        check("post_reset_dout1", 64'(dout[1*DW +: DW]), 64'hBEEF);
        applyStimulus(1'b0, 2'd0, 32'h0, 4'b0010, 1'b0, 4'b0010);
        checkOutput("post_reset_drain", 16'h5555, 4'hF, 4'h0);

        // Every queued word must have been consumed by the monitor
        for (int v = 0; v < NV; v++) check($sformatf("queue_left_vc%0d", v), 64'(expQ[v].size()), 64'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
